// File: rtl/eth_mdio_master.sv
// eth_mdio_master
// IEEE 802.3 Clause 22 MDIO management master. One command at a time is
// serialised into a 64-bit frame (preamble, ST, OP, PHYAD, REGAD, TA, data)
// on mdio_o/mdio_oe, clocked out against a divided management clock mdc.
// Read frames release the line from the turnaround onward and capture the
// PHY's answer on each MDC rising edge.
//
// Ports
//   clock        in   single clock for all logic
//   reset        in   synchronous, active-high reset
//   cmd_valid    in   command request
//   cmd_ready    out  high while idle and not in reset
//   cmd_write    in   1 = write, 0 = read
//   cmd_phy_addr in   [4:0] PHY address
//   cmd_reg_addr in   [4:0] register address
//   cmd_wdata    in   [15:0] write data
//   rsp_valid    out  one-cycle completion pulse
//   rsp_rdata    out  [15:0] read data, held until the next completion
//   rsp_error    out  turnaround error (no PHY pulled TA low), held
//   mdc          out  management clock to the PHY
//   mdio_o       out  MDIO output value
//   mdio_oe      out  MDIO output enable, 1 = drive
//   mdio_i       in   MDIO pad input
module eth_mdio_master #(
    parameter int unsigned CLK_DIV = 25
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [4:0]  cmd_phy_addr,
    input  logic [4:0]  cmd_reg_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_error,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FRAME = 1'b1
    } state_t;

    // The divider counts one MDC half-period; mdc itself is the phase bit.
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state_r,     state_s;
    logic [7:0]  div_r,       div_s;
    logic [5:0]  bit_r,       bit_s;
    logic [63:0] frame_r,     frame_s;
    logic        write_r,     write_s;
    logic [15:0] shift_r,     shift_s;
    logic        smp_err_r,   smp_err_s;
    logic        mdc_r,       mdc_s;
    logic        mdio_o_r,    mdio_o_s;
    logic        mdio_oe_r,   mdio_oe_s;
    logic        rsp_valid_r, rsp_valid_s;
    logic [15:0] rsp_rdata_r, rsp_rdata_s;
    logic        rsp_error_r, rsp_error_s;

    assign cmd_ready = (state_r == IDLE) && !reset;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_error = rsp_error_r;
    assign mdc       = mdc_r;
    assign mdio_o    = mdio_o_r;
    assign mdio_oe   = mdio_oe_r;

    // Next-state, counter and output computation for the frame sequencer.
    always_comb begin
        state_s     = state_r;
        div_s       = div_r;
        bit_s       = bit_r;
        frame_s     = frame_r;
        write_s     = write_r;
        shift_s     = shift_r;
        smp_err_s   = smp_err_r;
        mdc_s       = mdc_r;
        mdio_o_s    = mdio_o_r;
        mdio_oe_s   = mdio_oe_r;
        rsp_valid_s = 1'b0;
        rsp_rdata_s = rsp_rdata_r;
        rsp_error_s = rsp_error_r;
        case (state_r)
            IDLE: begin
                mdc_s     = 1'b0;
                mdio_o_s  = 1'b1;
                mdio_oe_s = 1'b0;
                if (cmd_valid) begin
                    state_s   = FRAME;
                    div_s     = 8'd0;
                    bit_s     = 6'd0;
                    write_s   = cmd_write;
                    // Read frames carry 1s after REGAD; they are never driven.
                    frame_s   = {32'hFFFF_FFFF, 2'b01,
                                 cmd_write ? 2'b01 : 2'b10,
                                 cmd_phy_addr, cmd_reg_addr,
                                 cmd_write ? 2'b10 : 2'b11,
                                 cmd_write ? cmd_wdata : 16'hFFFF};
                    mdio_o_s  = 1'b1;
                    mdio_oe_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            FRAME: begin
                if (div_r == DIV_LAST) begin
                    div_s = 8'd0;
                    if (!mdc_r) begin
                        // MDC rising edge: this is where the PHY's bit is sampled.
                        mdc_s = 1'b1;
                        if (bit_r == 6'd47) begin
                            smp_err_s = mdio_i;
                        end else if (bit_r >= 6'd48) begin
                            shift_s = {shift_r[14:0], mdio_i};
                        end else begin
                            shift_s = shift_r;
                        end
                    end else if (bit_r == 6'd63) begin
                        // End of the last period: report and go idle.
                        state_s     = IDLE;
                        mdc_s       = 1'b0;
                        mdio_o_s    = 1'b1;
                        mdio_oe_s   = 1'b0;
                        rsp_valid_s = 1'b1;
                        if (write_r) begin
                            rsp_error_s = 1'b0;
                        end else begin
                            rsp_rdata_s = shift_r;
                            rsp_error_s = smp_err_r;
                        end
                    end else begin
                        // MDC falling edge: present the next frame bit.
                        mdc_s     = 1'b0;
                        bit_s     = bit_r + 6'd1;
                        mdio_o_s  = frame_r[62];
                        frame_s   = {frame_r[62:0], 1'b1};
                        mdio_oe_s = write_r || (bit_r < 6'd45);
                    end
                end else begin
                    div_s = div_r + 8'd1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= IDLE;
            div_r       <= 8'd0;
            bit_r       <= 6'd0;
            frame_r     <= 64'd0;
            write_r     <= 1'b0;
            shift_r     <= 16'd0;
            smp_err_r   <= 1'b0;
            mdc_r       <= 1'b0;
            mdio_o_r    <= 1'b1;
            mdio_oe_r   <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 16'd0;
            rsp_error_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            div_r       <= div_s;
            bit_r       <= bit_s;
            frame_r     <= frame_s;
            write_r     <= write_s;
            shift_r     <= shift_s;
            smp_err_r   <= smp_err_s;
            mdc_r       <= mdc_s;
            mdio_o_r    <= mdio_o_s;
            mdio_oe_r   <= mdio_oe_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_rdata_r <= rsp_rdata_s;
            rsp_error_r <= rsp_error_s;
        end
    end

endmodule

// File: tb/tb_eth_mdio_master.sv
// tb_eth_mdio_master
// Two instances: index 0 with CLK_DIV=2, index 1 with CLK_DIV=1. A timing
// model derives every expected output from the accept cycle T and the frame
// layout (period k covers cycles T+1+2Dk .. T+2D(k+1)), and also plays the
// PHY on mdio_i. A compare process checks all outputs every cycle; a few
// literal expectations pin the model.
module tb_eth_mdio_master;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst = 2'b11;
    logic [1:0]  cmd_valid_v = 2'b00;
    logic [1:0]  cmd_write_v = 2'b00;
    logic [4:0]  phy_v [2];
    logic [4:0]  reg_v [2];
    logic [15:0] wd_v  [2];
    logic [1:0]  mdio_i_v = 2'b11;
    logic [1:0]  rdy, vld, rerr, mdc_v, mo, moe;
    logic [15:0] rd    [2];

    eth_mdio_master #(.CLK_DIV(2)) u_dut0 (
        .clock(clk), .reset(rst[0]), .cmd_valid(cmd_valid_v[0]), .cmd_ready(rdy[0]),
        .cmd_write(cmd_write_v[0]), .cmd_phy_addr(phy_v[0]), .cmd_reg_addr(reg_v[0]),
        .cmd_wdata(wd_v[0]), .rsp_valid(vld[0]), .rsp_rdata(rd[0]), .rsp_error(rerr[0]),
        .mdc(mdc_v[0]), .mdio_o(mo[0]), .mdio_oe(moe[0]), .mdio_i(mdio_i_v[0]));

    eth_mdio_master #(.CLK_DIV(1)) u_dut1 (
        .clock(clk), .reset(rst[1]), .cmd_valid(cmd_valid_v[1]), .cmd_ready(rdy[1]),
        .cmd_write(cmd_write_v[1]), .cmd_phy_addr(phy_v[1]), .cmd_reg_addr(reg_v[1]),
        .cmd_wdata(wd_v[1]), .rsp_valid(vld[1]), .rsp_rdata(rd[1]), .rsp_error(rerr[1]),
        .mdc(mdc_v[1]), .mdio_o(mo[1]), .mdio_oe(moe[1]), .mdio_i(mdio_i_v[1]));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // model state per instance
    bit          chk_en  [2];
    bit          act     [2];
    int          t_acc   [2];
    int          acc_cnt [2];
    bit          m_wr    [2];
    logic [4:0]  m_phy   [2];
    logic [4:0]  m_reg   [2];
    logic [15:0] m_wd    [2];
    bit          m_pres  [2];
    logic [15:0] m_pdata [2];
    logic [15:0] exp_rd  [2];
    bit          exp_err [2];
    // PHY behaviour requested by the stimulus for the next command
    bit          phy_pres [2];
    logic [15:0] phy_data [2];

    // observations on instance 0
    logic [63:0] stream0 = 64'd0;
    bit          prev_mdc0 = 1'b0;
    int          oe_cnt0 = 0;

    function automatic int dv(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic logic [63:0] frame_of(input bit wr, input logic [4:0] p,
                                             input logic [4:0] r, input logic [15:0] d);
        return {32'hFFFF_FFFF, 2'b01, wr ? 2'b01 : 2'b10, p, r,
                wr ? 2'b10 : 2'b11, wr ? d : 16'hFFFF};
    endfunction

    task automatic chk(input string nm, input int i, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s[%0d] got=%0h want=%0h cyc=%0d", nm, i, got, want, cyc);
        end
    endtask

    // Model: accept/abort decisions at each clock edge.
    initial begin
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rst[i]) begin
                    act[i]     = 1'b0;
                    exp_rd[i]  = 16'd0;
                    exp_err[i] = 1'b0;
                    chk_en[i]  = 1'b1;
                end else if (cmd_valid_v[i] &&
                             (!act[i] || (cyc - t_acc[i] >= 128 * dv(i) + 1))) begin
                    act[i]     = 1'b1;
                    t_acc[i]   = cyc;
                    m_wr[i]    = cmd_write_v[i];
                    m_phy[i]   = phy_v[i];
                    m_reg[i]   = reg_v[i];
                    m_wd[i]    = wd_v[i];
                    m_pres[i]  = phy_pres[i];
                    m_pdata[i] = phy_data[i];
                    acc_cnt[i] = acc_cnt[i] + 1;
                end
            end
            cyc = cyc + 1;
        end
    end

    // Compare process: every cycle, mid-cycle, for both instances.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                int c, d, k, ph;
                bit infr, cmpl, e_mdc, e_o, e_oe;
                logic [63:0] f;
                d    = dv(i);
                c    = cyc - t_acc[i];
                infr = act[i] && (c >= 1) && (c <= 128 * d);
                cmpl = act[i] && (c == 128 * d + 1);
                e_mdc = 1'b0; e_o = 1'b1; e_oe = 1'b0;
                mdio_i_v[i] = 1'b1;
                if (infr) begin
                    k  = (c - 1) / (2 * d);
                    ph = (c - 1) % (2 * d);
                    f  = frame_of(m_wr[i], m_phy[i], m_reg[i], m_wd[i]);
                    e_mdc = (ph >= d);
                    e_oe  = m_wr[i] || (k < 46);
                    e_o   = f[63 - k];
                    if (!m_wr[i] && m_pres[i] && k == 47)
                        mdio_i_v[i] = 1'b0;
                    else if (!m_wr[i] && m_pres[i] && k >= 48)
                        mdio_i_v[i] = m_pdata[i][63 - k];
                end
                if (cmpl) begin
                    if (m_wr[i]) begin
                        exp_err[i] = 1'b0;
                    end else begin
                        exp_rd[i]  = m_pres[i] ? m_pdata[i] : 16'hFFFF;
                        exp_err[i] = !m_pres[i];
                    end
                end
                if (chk_en[i]) begin
                    chk("mdc", i, {31'd0, mdc_v[i]}, {31'd0, e_mdc});
                    chk("mdio_oe", i, {31'd0, moe[i]}, {31'd0, e_oe});
                    if (e_oe) chk("mdio_o", i, {31'd0, mo[i]}, {31'd0, e_o});
                    chk("rsp_valid", i, {31'd0, vld[i]}, {31'd0, cmpl});
                    chk("cmd_ready", i, {31'd0, rdy[i]}, {31'd0, !rst[i] && !infr});
                    chk("rsp_rdata", i, {16'd0, rd[i]}, {16'd0, exp_rd[i]});
                    chk("rsp_error", i, {31'd0, rerr[i]}, {31'd0, exp_err[i]});
                end
            end
            if (mdc_v[0] && !prev_mdc0) stream0 = {stream0[62:0], mo[0]};
            prev_mdc0 = mdc_v[0];
            if (moe[0]) oe_cnt0++;
        end
    end

    // Present a command; returns at the cycle after it is accepted.
    task automatic issue(input int i, input bit wr, input logic [4:0] p, input logic [4:0] r,
                         input logic [15:0] d, input bit pres, input logic [15:0] pd,
                         input bit hold);
        int a0;
        bit ok;
        a0 = acc_cnt[i];
        ok = 1'b0;
        @(posedge clk); #1;
        cmd_write_v[i] = wr; phy_v[i] = p; reg_v[i] = r; wd_v[i] = d;
        phy_pres[i] = pres; phy_data[i] = pd;
        cmd_valid_v[i] = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            @(posedge clk); #1;
            if (acc_cnt[i] != a0) begin ok = 1'b1; break; end
        end
        if (!hold) cmd_valid_v[i] = 1'b0;
        chk("accept_timeout", i, {31'd0, ok}, 32'd1);
    endtask

    // Wait (bounded) for rsp_valid; reports the cycle it was seen in.
    task automatic wait_done(input int i, output int when);
        bit ok;
        ok = 1'b0;
        when = -1;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (vld[i]) begin ok = 1'b1; when = cyc; break; end
        end
        chk("rsp_timeout", i, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        int w, w1;
        for (int i = 0; i < 2; i++) begin
            phy_v[i] = 5'd0; reg_v[i] = 5'd0; wd_v[i] = 16'd0;
            phy_pres[i] = 1'b0; phy_data[i] = 16'd0;
            act[i] = 1'b0; chk_en[i] = 1'b0; t_acc[i] = 0; acc_cnt[i] = 0;
            exp_rd[i] = 16'd0; exp_err[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 2'b00;
        @(negedge clk);
        chk("reset_rdata", 0, {16'd0, rd[0]}, 32'd0);
        chk("reset_ready", 0, {31'd0, rdy[0]}, 32'd1);

        // model pin: the reference write frame
        chk("frame_lit_hi", 0, frame_of(1'b1, 5'd1, 5'd0, 16'h1140) >> 32, 32'hFFFF_FFFF);
        chk("frame_lit_lo", 0, frame_of(1'b1, 5'd1, 5'd0, 16'h1140) & 64'hFFFF_FFFF, 32'h5082_1140);

        // CLK_DIV=1 write
        issue(1, 1'b1, 5'd3, 5'd5, 16'h8001, 1'b0, 16'd0, 1'b0);
        wait_done(1, w);
        chk("latency_div1", 1, w - t_acc[1], 32'd129);

        // CLK_DIV=2 write PHY 1 reg 0 0x1140
        stream0 = 64'd0; oe_cnt0 = 0;
        issue(0, 1'b1, 5'd1, 5'd0, 16'h1140, 1'b0, 16'd0, 1'b0);
        wait_done(0, w);
        chk("latency_div2", 0, w - t_acc[0], 32'd257);
        chk("stream_hi", 0, stream0[63:32], 32'hFFFF_FFFF);
        chk("stream_lo", 0, stream0[31:0], 32'h5082_1140);
        chk("oe_cycles", 0, oe_cnt0, 32'd256);

        // read with PHY answering 0x001C
        issue(0, 1'b0, 5'd1, 5'd2, 16'd0, 1'b1, 16'h001C, 1'b0);
        wait_done(0, w);
        chk("read_data", 0, {16'd0, rd[0]}, 32'h001C);
        chk("read_err", 0, {31'd0, rerr[0]}, 32'd0);

        // read with no PHY
        issue(0, 1'b0, 5'd7, 5'd1, 16'd0, 1'b0, 16'd0, 1'b0);
        wait_done(0, w);
        chk("nophy_data", 0, {16'd0, rd[0]}, 32'hFFFF);
        chk("nophy_err", 0, {31'd0, rerr[0]}, 32'd1);

        // back-to-back: cmd_valid stays high across two commands
        issue(0, 1'b1, 5'd2, 5'd3, 16'hA5A5, 1'b0, 16'd0, 1'b1);
        cmd_write_v[0] = 1'b0; phy_v[0] = 5'd4; reg_v[0] = 5'd4;
        phy_pres[0] = 1'b1; phy_data[0] = 16'hBEEF;
        wait_done(0, w1);
        @(posedge clk); #1;
        cmd_valid_v[0] = 1'b0;
        chk("b2b_accept", 0, t_acc[0], w1);
        wait_done(0, w);
        chk("b2b_data", 0, {16'd0, rd[0]}, 32'hBEEF);

        // cmd_valid pulses during a frame are ignored
        issue(0, 1'b1, 5'd9, 5'd9, 16'h1234, 1'b0, 16'd0, 1'b0);
        for (int p = 0; p < 3; p++) begin
            repeat (20) @(posedge clk);
            #1 cmd_valid_v[0] = 1'b1; cmd_write_v[0] = 1'b0;
            @(negedge clk);
            chk("busy_ready", 0, {31'd0, rdy[0]}, 32'd0);
            @(posedge clk); #1 cmd_valid_v[0] = 1'b0;
        end
        wait_done(0, w);
        chk("busy_latency", 0, w - t_acc[0], 32'd257);

        // reset at bit 20 of a read
        issue(0, 1'b0, 5'd1, 5'd2, 16'd0, 1'b1, 16'h5555, 1'b0);
        repeat (80) @(posedge clk);
        #1 rst[0] = 1'b1;
        @(posedge clk); #1 rst[0] = 1'b0;
        @(negedge clk);
        chk("abort_mdc", 0, {31'd0, mdc_v[0]}, 32'd0);
        chk("abort_oe", 0, {31'd0, moe[0]}, 32'd0);
        chk("abort_ready", 0, {31'd0, rdy[0]}, 32'd1);
        repeat (300) @(posedge clk);
        issue(0, 1'b0, 5'd1, 5'd2, 16'd0, 1'b1, 16'h0F0F, 1'b0);
        wait_done(0, w);
        chk("after_abort", 0, {16'd0, rd[0]}, 32'h0F0F);

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/eth_mdio_master.md
ETH_MDIO_MASTER -- requirements
Module: eth_mdio_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 25, MDC half-period in clock cycles; legal range 1..255 (125 MHz / 50 = 2.5 MHz MDC).
REQ-002 SHALL have port clock  input  1  single clock for all logic.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port cmd_valid  input  1  command request.
REQ-005 SHALL have port cmd_ready  output  1  block can accept a command.
REQ-006 SHALL have port cmd_write  input  1  1 = write, 0 = read.
REQ-007 SHALL have port cmd_phy_addr  input  5  PHY address.
REQ-008 SHALL have port cmd_reg_addr  input  5  register address.
REQ-009 SHALL have port cmd_wdata  input  16  write data.
REQ-010 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rsp_rdata  output  16  read data, held until next completion.
REQ-012 SHALL have port rsp_error  output  1  read turnaround error, held until next completion.
REQ-013 SHALL have port mdc  output  1  management clock to PHY.
REQ-014 SHALL have port mdio_o  output  1  MDIO output value.
REQ-015 SHALL have port mdio_oe  output  1  MDIO output enable, 1 = drive.
REQ-016 SHALL have port mdio_i  input  1  MDIO pad input.

Function
REQ-017 SHALL use states IDLE and FRAME; cmd_ready = 1 exactly when in IDLE and reset is low.
REQ-018 SHALL accept a command on a clock edge with cmd_valid && cmd_ready, latch all cmd_* fields, enter FRAME next cycle; cmd_valid during FRAME SHALL be ignored.
REQ-019 SHALL emit a 64-bit Clause 22 frame, MSB first: bits 0-31 preamble all 1; 32-33 ST = 01; 34-35 OP = 01 write / 10 read; 36-40 PHYAD; 41-45 REGAD; 46-47 TA; 48-63 data.
REQ-020 SHALL, for writes, drive TA = 10 and data = cmd_wdata with mdio_oe = 1 for bits 0-63.
REQ-021 SHALL, for reads, drive mdio_oe = 1 for bits 0-45 and mdio_oe = 0 for bits 46-63.
REQ-022 SHALL give frame bit k (0..63) the MDC period of cycles T+1+2*CLK_DIV*k .. T+2*CLK_DIV*(k+1), T = accept cycle; mdc = 0 for the first CLK_DIV cycles of each period, 1 for the last CLK_DIV.
REQ-023 SHALL update mdio_o/mdio_oe only at period starts (MDC falling edge or frame start), giving PHY CLK_DIV cycles of setup before each MDC rise.
REQ-024 SHALL register mdio_i on the clock edge that sets mdc to 1; read period 47 sample → rsp_error (1 = no PHY drove 0); periods 48..63 → rsp_rdata[63-k].
REQ-025 SHALL, in cycle T+1+128*CLK_DIV, return to IDLE, pulse rsp_valid for one cycle, update rsp_rdata/rsp_error (writes: rsp_rdata unchanged, rsp_error = 0), and assert cmd_ready.
REQ-026 SHALL accept a new command in the rsp_valid cycle if cmd_valid is high (back-to-back, no idle gap).
REQ-027 SHALL in IDLE hold mdc = 0, mdio_o = 1, mdio_oe = 0.
REQ-028 SHALL use an 8-bit divider counter and 6-bit bit counter, both cleared at accept; no wrap beyond bit 63.

Reset
REQ-029 SHALL, on any clock edge with reset = 1 (including mid-frame), enter IDLE next cycle with mdc = 0, mdio_o = 1, mdio_oe = 0, rsp_valid = 0, rsp_rdata = 0, rsp_error = 0, cmd_ready = 0 while reset high; an aborted frame SHALL NOT produce rsp_valid.

Verification
REQ-030 CLK_DIV=2, write PHY 1 reg 0 data 0x1140 → serial stream 32x1,01,01,00001,00000,10,0001000101000000; rsp_valid at T+257; mdio_oe high for 256 cycles.
REQ-031 CLK_DIV=2, read PHY 1 reg 2, PHY model drives 0 at bit 47 and 0x001C in bits 48-63 → rsp_rdata = 0x001C, rsp_error = 0, mdio_oe low from bit 46.
REQ-032 Read with mdio_i held 1 (no PHY) → rsp_rdata = 0xFFFF, rsp_error = 1.
REQ-033 cmd_valid held high for two commands → second accepted in first's rsp_valid cycle; cmd_valid pulses during FRAME ignored (cmd_ready = 0).
REQ-034 reset asserted at bit 20 of a read → next cycle IDLE, mdc = 0, mdio_oe = 0, no rsp_valid; following command completes normally.
REQ-035 CLK_DIV=1 write → mdc toggles every cycle, rsp_valid at T+129.
